// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: PC, one-outstanding req/ack fetch FSM, and a DEPTH-entry prefetch queue.
// Optional build macro FETCH_PREFETCH_STATS_EN adds stat_redirects / stat_discards counters.
module fetch_prefetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              Branch_taken,
  input  logic [ADDR_W-1:0] Branch_target,
  input  logic              Jump,
  input  logic [ADDR_W-1:0] Jump_target,
  output logic              inst_valid,
  output logic [DATA_W-1:0] Inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
`ifdef FETCH_PREFETCH_STATS_EN
  output logic [15:0]       stat_redirects,
  output logic [15:0]       stat_discards,
`endif
  output logic [1:0]        dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [ADDR_W-1:0] mem_pc_q   [DEPTH];

  logic              redirect;
  logic [ADDR_W-1:0] redirect_tgt;
  logic              fire;
  logic              push;
  logic              pop;
  logic              drop;

  // Handshakes: a fetch completes in any cycle with imem_req & imem_ack (req and
  // address held until then); decode takes the head in any cycle with inst_valid & inst_ready.
  always_comb begin
    redirect     = Jump | Branch_taken;
    redirect_tgt = (Jump ? Jump_target : Branch_target) & ~ADDR_W'(3);
    fire         = (state_q != S_IDLE) && imem_ack;
    push         = (state_q == S_REQ) && imem_ack && !redirect;
    pop          = inst_valid && inst_ready && !redirect;
    drop         = fire && ((state_q == S_DISCARD) || redirect);
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // In DISCARD pc_q keeps the in-flight address so the request stays stable;
  // the pending redirect target waits in tgt_q until the stale ack arrives.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    case (state_q)
      S_IDLE: begin
        if (redirect) begin
          pc_d    = redirect_tgt;
          state_d = S_REQ;
        end else if (count_q < DEPTH_C) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (redirect) begin
          if (imem_ack) begin
            pc_d    = redirect_tgt;
            state_d = S_REQ;
          end else begin
            tgt_d   = redirect_tgt;
            state_d = S_DISCARD;
          end
        end else if (imem_ack) begin
          pc_d    = pc_q + ADDR_W'(4);
          state_d = (count_d < DEPTH_C) ? S_REQ : S_IDLE;
        end
      end
      S_DISCARD: begin
        if (redirect) tgt_d = redirect_tgt;
        if (imem_ack) begin
          pc_d    = redirect ? redirect_tgt : tgt_q;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      tgt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      tgt_q    <= tgt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= imem_rdata;
      mem_pc_q[wr_ptr_q]   <= pc_q;
    end
  end

  always_comb begin
    imem_req   = (state_q != S_IDLE);
    imem_addr  = pc_q;
    inst_valid = (count_q != '0);
    Inst       = inst_valid ? mem_data_q[rd_ptr_q] : '0;
    inst_pc    = inst_valid ? mem_pc_q[rd_ptr_q]   : '0;
    dbg_state  = state_q;
  end

`ifdef FETCH_PREFETCH_STATS_EN
  logic [15:0] stat_redir_q, stat_redir_d;
  logic [15:0] stat_disc_q, stat_disc_d;

  always_comb begin
    stat_redir_d = stat_redir_q;
    stat_disc_d  = stat_disc_q;
    if (redirect && (stat_redir_q != 16'hFFFF)) stat_redir_d = stat_redir_q + 16'd1;
    if (drop && (stat_disc_q != 16'hFFFF))      stat_disc_d  = stat_disc_q + 16'd1;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      stat_redir_q <= '0;
      stat_disc_q  <= '0;
    end else begin
      stat_redir_q <= stat_redir_d;
      stat_disc_q  <= stat_disc_d;
    end
  end

  assign stat_redirects = stat_redir_q;
  assign stat_discards  = stat_disc_q;
`endif

  // The FSM leaves REQ before the queue fills, so a live request never targets a full queue.
  a_no_req_when_full: assert property (@(posedge Clock) disable iff (Reset)
    (state_q == S_REQ) |-> (count_q != DEPTH_C));

  a_req_stable: assert property (@(posedge Clock) disable iff (Reset)
    (imem_req && !imem_ack) |=> (imem_req && $stable(imem_addr)));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: constant vector table, hand-written redirect/reset sequences,
// and randomized traffic compared cycle by cycle against a queue-based reference model.
module tb_fetch_prefetch_unit;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int NI    = 2;

  typedef struct {
    logic        ack;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic        wchk;
    logic        w_req;
    logic [31:0] w_addr;
  } vec_t;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        imem_ack = 1'b0;
  logic        inst_ready = 1'b0;
  logic        Branch_taken = 1'b0;
  logic        Jump = 1'b0;
  logic [31:0] Branch_target = '0;
  logic [31:0] Jump_target = '0;

  logic        d_req   [NI];
  logic [31:0] d_addr  [NI];
  logic [31:0] d_rdata [NI];
  logic        d_valid [NI];
  logic [31:0] d_inst  [NI];
  logic [31:0] d_pc    [NI];
  logic [1:0]  d_state [NI];
`ifdef FETCH_PREFETCH_STATS_EN
  logic [15:0] d_sr [NI];
  logic [15:0] d_sd [NI];
  int          m_sr [NI];
  int          m_sd [NI];
`endif

  // reference model: pending fetches as {pc, data} entries in decode order
  logic [63:0] exp_q [NI][$];
  bit          m_active [NI];
  bit          m_drop   [NI];
  logic [31:0] m_addr   [NI];
  logic [31:0] m_fetch  [NI];
  logic [31:0] rst_pc   [NI];

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
  endfunction

  assign d_rdata[0] = mem_word(d_addr[0]);
  assign d_rdata[1] = mem_word(d_addr[1]);

  always #5 Clock = ~Clock;

  fetch_prefetch_unit #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESET_PC(32'h0000_3000)) u_dut (
    .Clock(Clock), .Reset(Reset),
    .imem_req(d_req[0]), .imem_addr(d_addr[0]), .imem_ack(imem_ack), .imem_rdata(d_rdata[0]),
    .Branch_taken(Branch_taken), .Branch_target(Branch_target),
    .Jump(Jump), .Jump_target(Jump_target),
    .inst_valid(d_valid[0]), .Inst(d_inst[0]), .inst_pc(d_pc[0]), .inst_ready(inst_ready),
`ifdef FETCH_PREFETCH_STATS_EN
    .stat_redirects(d_sr[0]), .stat_discards(d_sd[0]),
`endif
    .dbg_state(d_state[0])
  );

  fetch_prefetch_unit #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .Clock(Clock), .Reset(Reset),
    .imem_req(d_req[1]), .imem_addr(d_addr[1]), .imem_ack(imem_ack), .imem_rdata(d_rdata[1]),
    .Branch_taken(Branch_taken), .Branch_target(Branch_target),
    .Jump(Jump), .Jump_target(Jump_target),
    .inst_valid(d_valid[1]), .Inst(d_inst[1]), .inst_pc(d_pc[1]), .inst_ready(inst_ready),
`ifdef FETCH_PREFETCH_STATS_EN
    .stat_redirects(d_sr[1]), .stat_discards(d_sd[1]),
`endif
    .dbg_state(d_state[1])
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    rst_pc[0] = 32'h0000_3000;
    rst_pc[1] = 32'hFFFF_FFF8;
    for (int i = 0; i < NI; i++) begin
      exp_q[i].delete();
      m_active[i] = 1'b0;
      m_drop[i]   = 1'b0;
      m_addr[i]   = rst_pc[i];
      m_fetch[i]  = rst_pc[i];
`ifdef FETCH_PREFETCH_STATS_EN
      m_sr[i] = 0;
      m_sd[i] = 0;
`endif
    end
  endtask

  task automatic model_check();
    int          sz;
    logic [63:0] head;
    for (int i = 0; i < NI; i++) begin
      sz   = exp_q[i].size();
      head = (sz != 0) ? exp_q[i][0] : 64'd0;
      check32($sformatf("imem_req[%0d]", i), 32'(d_req[i]), 32'(m_active[i]));
      if (m_active[i]) check32($sformatf("imem_addr[%0d]", i), d_addr[i], m_addr[i]);
      check32($sformatf("inst_valid[%0d]", i), 32'(d_valid[i]), 32'(sz != 0));
      check32($sformatf("inst_pc[%0d]", i), d_pc[i], head[63:32]);
      check32($sformatf("Inst[%0d]", i), d_inst[i], head[31:0]);
`ifdef FETCH_PREFETCH_STATS_EN
      check32($sformatf("stat_redirects[%0d]", i), 32'(d_sr[i]), 32'(m_sr[i]));
      check32($sformatf("stat_discards[%0d]", i), 32'(d_sd[i]), 32'(m_sd[i]));
`endif
    end
  endtask

  // Advances the model by one clock given this cycle's inputs.
  task automatic model_step(input logic ack, input logic rdy, input logic redir, input logic [31:0] tgt);
    int sz_before;
    bit acked;
    for (int i = 0; i < NI; i++) begin
      sz_before = exp_q[i].size();
      acked     = m_active[i] && ack;
`ifdef FETCH_PREFETCH_STATS_EN
      if (redir && m_sr[i] < 65535) m_sr[i]++;
      if (acked && (redir || m_drop[i]) && m_sd[i] < 65535) m_sd[i]++;
`endif
      if (redir) begin
        exp_q[i].delete();
        m_fetch[i] = tgt;
        if (m_active[i] && !ack) begin
          m_drop[i] = 1'b1;
        end else begin
          m_active[i] = 1'b1;
          m_drop[i]   = 1'b0;
          m_addr[i]   = tgt;
        end
      end else begin
        if (sz_before != 0 && rdy) void'(exp_q[i].pop_front());
        if (acked && m_drop[i]) begin
          m_drop[i] = 1'b0;
          m_addr[i] = m_fetch[i];
        end else if (acked) begin
          exp_q[i].push_back({m_addr[i], mem_word(m_addr[i])});
          m_fetch[i]  = m_addr[i] + 32'd4;
          m_addr[i]   = m_fetch[i];
          m_active[i] = (exp_q[i].size() < DEPTH);
        end else if (!m_active[i] && sz_before < DEPTH) begin
          m_active[i] = 1'b1;
          m_addr[i]   = m_fetch[i];
        end
      end
    end
  endtask

  task automatic cycle(input logic ack, input logic rdy, input logic br, input logic [31:0] bt,
                       input logic jmp, input logic [31:0] jt);
    @(negedge Clock);
    imem_ack      = ack;
    inst_ready    = rdy;
    Branch_taken  = br;
    Branch_target = bt;
    Jump          = jmp;
    Jump_target   = jt;
    #1;
    model_check();
    if (Reset) model_reset();
    else model_step(ack, rdy, br | jmp, (jmp ? jt : bt) & ~32'h3);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    model_reset();
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < NI; i++) check32($sformatf("reset_state[%0d]", i), 32'(d_state[i]), 32'd0);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
  endtask

  function automatic vec_t mk(input logic ack, input logic rdy, input logic req, input logic [31:0] addr,
                              input logic valid, input logic [31:0] pc,
                              input logic wchk, input logic w_req, input logic [31:0] w_addr);
    vec_t v;
    v.ack = ack; v.rdy = rdy; v.req = req; v.addr = addr; v.valid = valid; v.pc = pc;
    v.wchk = wchk; v.w_req = w_req; v.w_addr = w_addr;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [12];
    logic [31:0] bt, jt;
    logic        br, jmp;

    // fill-to-full from 0x3000 with ready low, then drain with ready high
    vt[0]  = mk(1, 0, 0, 32'h0,    0, 32'h0,    0, 0, 32'h0);
    vt[1]  = mk(1, 0, 1, 32'h3000, 0, 32'h0,    1, 1, 32'hFFFF_FFF8);
    vt[2]  = mk(1, 0, 1, 32'h3004, 1, 32'h3000, 1, 1, 32'hFFFF_FFFC);
    vt[3]  = mk(1, 0, 1, 32'h3008, 1, 32'h3000, 1, 1, 32'h0000_0000);
    vt[4]  = mk(1, 0, 1, 32'h300C, 1, 32'h3000, 1, 1, 32'h0000_0004);
    vt[5]  = mk(1, 0, 0, 32'h0,    1, 32'h3000, 1, 0, 32'h0);
    vt[6]  = mk(1, 1, 0, 32'h0,    1, 32'h3000, 0, 0, 32'h0);
    vt[7]  = mk(1, 1, 0, 32'h0,    1, 32'h3004, 0, 0, 32'h0);
    vt[8]  = mk(1, 1, 1, 32'h3010, 1, 32'h3008, 0, 0, 32'h0);
    vt[9]  = mk(1, 1, 1, 32'h3014, 1, 32'h300C, 0, 0, 32'h0);
    vt[10] = mk(1, 1, 1, 32'h3018, 1, 32'h3010, 0, 0, 32'h0);
    vt[11] = mk(1, 1, 1, 32'h301C, 1, 32'h3014, 0, 0, 32'h0);

    do_reset();
    for (int k = 0; k < 12; k++) begin
      cycle(vt[k].ack, vt[k].rdy, 1'b0, 32'h0, 1'b0, 32'h0);
      check32($sformatf("tbl%0d_req", k), 32'(d_req[0]), 32'(vt[k].req));
      if (vt[k].req) check32($sformatf("tbl%0d_addr", k), d_addr[0], vt[k].addr);
      check32($sformatf("tbl%0d_valid", k), 32'(d_valid[0]), 32'(vt[k].valid));
      check32($sformatf("tbl%0d_pc", k), d_pc[0], vt[k].pc);
      check32($sformatf("tbl%0d_inst", k), d_inst[0], vt[k].valid ? mem_word(vt[k].pc) : 32'h0);
      if (vt[k].wchk) begin
        check32($sformatf("tbl%0d_wrap_req", k), 32'(d_req[1]), 32'(vt[k].w_req));
        if (vt[k].w_req) check32($sformatf("tbl%0d_wrap_addr", k), d_addr[1], vt[k].w_addr);
      end
    end

    // branch while a request waits: the stale word is dropped, fetch resumes at 0x4000
    do_reset();
    cycle(0, 0, 0, 32'h0, 0, 32'h0);
    cycle(1, 0, 0, 32'h0, 0, 32'h0);
    cycle(1, 0, 0, 32'h0, 0, 32'h0);
    cycle(0, 0, 1, 32'h4000, 0, 32'h0);
    check32("disc_addr_before", d_addr[0], 32'h3008);
    cycle(0, 0, 0, 32'h0, 0, 32'h0);
    check32("disc_hold_req", 32'(d_req[0]), 32'd1);
    check32("disc_hold_addr", d_addr[0], 32'h3008);
    check32("disc_flushed", 32'(d_valid[0]), 32'd0);
    cycle(1, 0, 0, 32'h0, 0, 32'h0);
    check32("disc_ack_addr", d_addr[0], 32'h3008);
    cycle(1, 0, 0, 32'h0, 0, 32'h0);
    check32("disc_target_addr", d_addr[0], 32'h4000);
    check32("disc_no_push", 32'(d_valid[0]), 32'd0);
    cycle(0, 0, 0, 32'h0, 0, 32'h0);
    check32("disc_first_valid", 32'(d_valid[0]), 32'd1);
    check32("disc_first_pc", d_pc[0], 32'h4000);
    check32("disc_first_inst", d_inst[0], mem_word(32'h4000));
`ifdef FETCH_PREFETCH_STATS_EN
    check32("disc_stat_discards", 32'(d_sd[0]), 32'd1);
    check32("disc_stat_redirects", 32'(d_sr[0]), 32'd1);
`endif

    // jump beats branch in a cycle that also pops and acks; then steady one-per-cycle flow
    do_reset();
    cycle(1, 0, 0, 32'h0, 0, 32'h0);
    cycle(1, 0, 0, 32'h0, 0, 32'h0);
    cycle(1, 1, 1, 32'h6000, 1, 32'h5003);
    check32("jb_pre_valid", 32'(d_valid[0]), 32'd1);
    check32("jb_pre_pc", d_pc[0], 32'h3000);
    cycle(1, 1, 0, 32'h0, 0, 32'h0);
    check32("jb_flushed", 32'(d_valid[0]), 32'd0);
    check32("jb_req", 32'(d_req[0]), 32'd1);
    check32("jb_addr", d_addr[0], 32'h5000);
    for (int n = 1; n <= 10; n++) begin
      cycle(1, 1, 0, 32'h0, 0, 32'h0);
      check32($sformatf("flow%0d_valid", n), 32'(d_valid[0]), 32'd1);
      check32($sformatf("flow%0d_pc", n), d_pc[0], 32'h5000 + 32'(4 * (n - 1)));
      check32($sformatf("flow%0d_addr", n), d_addr[0], 32'h5000 + 32'(4 * n));
    end

    // asynchronous reset while a request is outstanding
    do_reset();
    cycle(0, 0, 0, 32'h0, 0, 32'h0);
    cycle(0, 0, 0, 32'h0, 0, 32'h0);
    check32("areset_pre_req", 32'(d_req[0]), 32'd1);
    Reset = 1'b1;
    model_reset();
    #1;
    check32("areset_req_drop", 32'(d_req[0]), 32'd0);
    check32("areset_valid", 32'(d_valid[0]), 32'd0);
    do_reset();
    cycle(1, 0, 0, 32'h0, 0, 32'h0);
    check32("areset_idle", 32'(d_req[0]), 32'd0);
    cycle(1, 0, 0, 32'h0, 0, 32'h0);
    check32("areset_restart_addr", d_addr[0], 32'h3000);
    check32("areset_empty", 32'(d_valid[0]), 32'd0);

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      br  = ($urandom_range(0, 19) == 0);
      jmp = ($urandom_range(0, 24) == 0);
      bt  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      jt  = $urandom;
      cycle(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 6), br, bt, jmp, jt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
